zregfile_mp: RTL and testbench
==============================

Name: zregfile_mp

Overview:
- Parametrised CPU register file: DEPTH registers of WIDTH bits, one synchronous write port and two combinational read ports.
- Includes a per-register busy scoreboard, so the control unit can reserve a destination register and stall on read-after-write hazards.
- Optional write-to-read bypass and optional hard-wired zero register.
- Sits between the decoder (register selects, reservations) and the ALU operand muxes.

Parameters:
- WIDTH, 8, data width of each register (>=1).
- DEPTH, 4, number of registers (power of 2, >=2); AW = $clog2(DEPTH).
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads show stored contents only.
- ZERO_REG, 0, 1 = register 0 always reads 0, and writes/reservations to it are ignored.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- WE  in  1  write enable
- WSEL  in  AW  write register select
- WDATA  in  WIDTH  write data
- RSEL_A  in  AW  read port A select
- OUT_A  out  WIDTH  read port A data
- RSEL_B  in  AW  read port B select
- OUT_B  out  WIDTH  read port B data
- RES_EN  in  1  reserve RES_SEL (mark pending write)
- RES_SEL  in  AW  register to reserve
- BUSY_A  out  1  source A has a pending write
- BUSY_B  out  1  source B has a pending write
- CLR  in  1  synchronous clear of all data and busy bits
- RES_ERR  out  1  registered pulse: reservation of an already-busy register
- BUSY_VEC  out  DEPTH  current busy bits, bit i = register i

Behaviour:
- Reset (RST_N low, async):
  - all registers become 0, all busy bits 0, RES_ERR 0.
  - This holds while RST_N is low and takes effect mid-operation with no clock.
- CLR (sync, priority over WE/RES_EN): same effect as reset at the next edge.
- Write:
  - at the rising edge with WE=1, regs[WSEL] <= WDATA and busy[WSEL] <= 0.
  - Latency 1; stored contents visible in the next cycle regardless of BYPASS.
- Reserve: at the rising edge with RES_EN=1, busy[RES_SEL] <= 1.
- Simultaneous write and reserve of the same register: the reserve wins, so busy stays or becomes 1 (a new pending producer). Data is still written.
- Reserve of an already-busy register (busy=1 before the edge, no same-cycle write to it):
  - RES_ERR = 1 for exactly the following cycle; busy stays 1.
  - Otherwise RES_ERR = 0 at each edge.
- Read (combinational, no latency):
  - OUT_x = regs[RSEL_x].
  - If BYPASS=1, WE=1 and WSEL==RSEL_x, then OUT_x = WDATA.
  - Both ports may select the same register.
- BUSY_x = busy[RSEL_x]. If BYPASS=1, WE=1 and WSEL==RSEL_x, BUSY_x = 0 (value is being forwarded).
- ZERO_REG=1:
  - OUT_x = 0 and BUSY_x = 0 when RSEL_x = 0.
  - Writes to register 0 are discarded; bypass never forwards to register 0.
  - RES_EN with RES_SEL=0 is ignored, with no RES_ERR.
  - busy[0] is constant 0.
- BUSY_VEC: registered busy bits, unaffected by bypass.
- No X-propagation: all selects are full-range because DEPTH is a power of 2.

Decomposition:
- Shared package zeph_pkg:
  - ZEPH_WIDTH=8 and ZEPH_NREGS=4 defaults.
  - reg_sel_t typedef (logic [AW-1:0]).
  - Named register index constants R0..R3.
- One natural sub-module, zregfile_rdport:
  - one combinational read port (select, bypass compare, zero-reg masking, busy lookup).
  - Instantiated twice, for A and B.
- Storage and scoreboard stay in the top module.

Test Plan:
- Reset/defaults: drive RST_N=0 mid-cycle after writing 8'hA5 to R2 -> OUT_A (RSEL_A=2) = 0 immediately, BUSY_VEC = 4'b0000; after release, reads all 0.
- Write/read and bypass: WE=1, WSEL=1, WDATA=8'h3C, RSEL_A=1 in the same cycle:
  - BYPASS=1 -> OUT_A = 8'h3C in that cycle.
  - BYPASS=0 -> OUT_A = 0 in that cycle, 8'h3C in the next.
- Scoreboard:
  - RES_EN, RES_SEL=3 -> next cycle BUSY_VEC = 4'b1000 and BUSY_B = 1 with RSEL_B=3.
  - Then WE, WSEL=3, WDATA=8'h7F -> BUSY_B = 0 in that cycle (BYPASS=1) and BUSY_VEC = 0 next.
- Collision: R2 not busy; same cycle RES_EN, RES_SEL=2 and WE, WSEL=2, WDATA=8'h11 -> next cycle regs[2] = 8'h11, busy[2] = 1, RES_ERR = 0. Reserve R2 again -> RES_ERR = 1 for one cycle.
- ZERO_REG=1:
  - WE, WSEL=0, WDATA=8'hFF -> OUT_A (RSEL_A=0) = 0 in the same cycle and after.
  - RES_EN, RES_SEL=0 -> BUSY_VEC[0] = 0, RES_ERR = 0.
- Parametrisation: WIDTH=16, DEPTH=8 -> write 16'hBEEF to R7, 16'h1234 to R0 -> OUT_A(7) = 16'hBEEF and OUT_B(0) = 16'h1234 simultaneously. CLR=1 -> both read 0 next cycle.

Source files
------------

// File: rtl/zeph_pkg.sv
// zeph_pkg: shared register-file defaults, select type and named register indices.
package zeph_pkg;
    localparam int ZEPH_WIDTH = 8;
    localparam int ZEPH_NREGS = 4;
    localparam int ZEPH_AW    = $clog2(ZEPH_NREGS);

    typedef logic [ZEPH_AW-1:0] reg_sel_t;

    localparam reg_sel_t R0 = reg_sel_t'(0);
    localparam reg_sel_t R1 = reg_sel_t'(1);
    localparam reg_sel_t R2 = reg_sel_t'(2);
    localparam reg_sel_t R3 = reg_sel_t'(3);
endpackage

// File: rtl/zregfile_rdport.sv
// zregfile_rdport: one combinational read port with write bypass, zero-register masking and busy lookup.
module zregfile_rdport #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic [AW-1:0]               rsel,
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    input  logic [DEPTH-1:0]            busy,
    input  logic                        we,
    input  logic [AW-1:0]               wsel,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_busy
);
    logic zero, fwd;

    always_comb begin
        zero    = ZERO_REG != 0 && rsel == '0;
        fwd     = BYPASS != 0 && we && wsel == rsel && !zero;
        rd_data = zero ? '0 : fwd ? wdata : regs[rsel];
        rd_busy = !zero && !fwd && busy[rsel];
    end
endmodule

// File: rtl/zregfile_mp.sv
// zregfile_mp: register file with one write port, two read ports and a busy scoreboard
// for read-after-write hazard detection.
module zregfile_mp
    import zeph_pkg::*;
#(
    parameter int WIDTH    = ZEPH_WIDTH,
    parameter int DEPTH    = ZEPH_NREGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rsel_a,
    output logic [WIDTH-1:0] out_a,
    input  logic [AW-1:0]    rsel_b,
    output logic [WIDTH-1:0] out_b,
    input  logic             res_en,
    input  logic [AW-1:0]    res_sel,
    output logic             busy_a,
    output logic             busy_b,
    input  logic             clr,
    output logic             res_err,
    output logic [DEPTH-1:0] busy_vec
);
    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy, busy_nxt;
    logic                        wr_ok, res_ok, err_nxt;

    always_comb begin
        wr_ok   = we && !(ZERO_REG != 0 && wsel == '0);
        res_ok  = res_en && !(ZERO_REG != 0 && res_sel == '0);
        // a same-cycle write to the reserved register retires the old producer, so no error
        err_nxt = res_ok && busy[res_sel] && !(wr_ok && wsel == res_sel);
        busy_nxt = busy;
        if (wr_ok) busy_nxt[wsel] = 1'b0;
        if (res_ok) busy_nxt[res_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            busy    <= '0;
            res_err <= 1'b0;
        end else if (clr) begin
            regs    <= '0;
            busy    <= '0;
            res_err <= 1'b0;
        end else begin
            if (wr_ok) regs[wsel] <= wdata;
            busy    <= busy_nxt;
            res_err <= err_nxt;
        end
    end

    assign busy_vec = busy;

    zregfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_rd_a (
        .rsel(rsel_a), .regs(regs), .busy(busy), .we(we), .wsel(wsel), .wdata(wdata),
        .rd_data(out_a), .rd_busy(busy_a)
    );

    zregfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)) u_rd_b (
        .rsel(rsel_b), .regs(regs), .busy(busy), .we(we), .wsel(wsel), .wdata(wdata),
        .rd_data(out_b), .rd_busy(busy_b)
    );
endmodule

// File: tb/tb_zregfile_mp.sv
// tb_zregfile_mp: four configurations driven by shared stimulus, checked every cycle against
// an array-based model, plus hand-computed expectations from the test plan.
module tb_zregfile_mp;
    logic        clk, rst_n, we, res_en, clr;
    logic [2:0]  wsel, rsel_a, rsel_b, res_sel;
    logic [15:0] wdata;

    // configs: 0 default, 1 no bypass, 2 zero register, 3 wide/deep
    int cw[4] = '{8, 8, 8, 16};
    int cd[4] = '{4, 4, 4, 8};
    int cb[4] = '{1, 0, 1, 1};
    int cz[4] = '{0, 0, 1, 0};

    logic [15:0] o_a[4], o_b[4];
    logic        ba[4], bb[4], re[4];
    logic [7:0]  bv[4];

    logic [7:0]  oa0, ob0, oa1, ob1, oa2, ob2;
    logic [15:0] oa3, ob3;
    logic [3:0]  bv0, bv1, bv2;
    logic [7:0]  bv3;

    zregfile_mp #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .ZERO_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel[1:0]), .wdata(wdata[7:0]),
        .rsel_a(rsel_a[1:0]), .out_a(oa0), .rsel_b(rsel_b[1:0]), .out_b(ob0),
        .res_en(res_en), .res_sel(res_sel[1:0]), .busy_a(ba[0]), .busy_b(bb[0]),
        .clr(clr), .res_err(re[0]), .busy_vec(bv0));
    zregfile_mp #(.WIDTH(8), .DEPTH(4), .BYPASS(0), .ZERO_REG(0)) u1 (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel[1:0]), .wdata(wdata[7:0]),
        .rsel_a(rsel_a[1:0]), .out_a(oa1), .rsel_b(rsel_b[1:0]), .out_b(ob1),
        .res_en(res_en), .res_sel(res_sel[1:0]), .busy_a(ba[1]), .busy_b(bb[1]),
        .clr(clr), .res_err(re[1]), .busy_vec(bv1));
    zregfile_mp #(.WIDTH(8), .DEPTH(4), .BYPASS(1), .ZERO_REG(1)) u2 (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel[1:0]), .wdata(wdata[7:0]),
        .rsel_a(rsel_a[1:0]), .out_a(oa2), .rsel_b(rsel_b[1:0]), .out_b(ob2),
        .res_en(res_en), .res_sel(res_sel[1:0]), .busy_a(ba[2]), .busy_b(bb[2]),
        .clr(clr), .res_err(re[2]), .busy_vec(bv2));
    zregfile_mp #(.WIDTH(16), .DEPTH(8), .BYPASS(1), .ZERO_REG(0)) u3 (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rsel_a(rsel_a), .out_a(oa3), .rsel_b(rsel_b), .out_b(ob3),
        .res_en(res_en), .res_sel(res_sel), .busy_a(ba[3]), .busy_b(bb[3]),
        .clr(clr), .res_err(re[3]), .busy_vec(bv3));

    assign o_a[0] = {8'h0, oa0};
    assign o_b[0] = {8'h0, ob0};
    assign o_a[1] = {8'h0, oa1};
    assign o_b[1] = {8'h0, ob1};
    assign o_a[2] = {8'h0, oa2};
    assign o_b[2] = {8'h0, ob2};
    assign o_a[3] = oa3;
    assign o_b[3] = ob3;
    assign bv[0]  = {4'h0, bv0};
    assign bv[1]  = {4'h0, bv1};
    assign bv[2]  = {4'h0, bv2};
    assign bv[3]  = bv3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    endtask

    // behavioural model: plain arrays of register values and pending-producer flags
    logic [15:0] mreg[4][8];
    bit          mbusy[4][8];
    bit          merr[4];
    int          m_ws, m_rs;
    bit          m_wok, m_rok;

    function automatic logic [15:0] wmask(int k);
        return 16'((32'd1 << cw[k]) - 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n || clr) begin
                for (int i = 0; i < 8; i++) begin
                    mreg[k][i]  = '0;
                    mbusy[k][i] = 0;
                end
                merr[k] = 0;
            end else begin
                m_ws  = int'(wsel) % cd[k];
                m_rs  = int'(res_sel) % cd[k];
                m_wok = we && !(cz[k] == 1 && m_ws == 0);
                m_rok = res_en && !(cz[k] == 1 && m_rs == 0);
                merr[k] = m_rok && mbusy[k][m_rs] && !(m_wok && m_ws == m_rs);
                if (m_wok) begin
                    mreg[k][m_ws]  = wdata & wmask(k);
                    mbusy[k][m_ws] = 0;
                end
                if (m_rok) mbusy[k][m_rs] = 1;
            end
        end
    end

    function automatic logic [15:0] exp_out(int k, logic [2:0] sel);
        int r = int'(sel) % cd[k];
        if (cz[k] == 1 && r == 0) return '0;
        if (cb[k] == 1 && we && int'(wsel) % cd[k] == r) return wdata & wmask(k);
        return mreg[k][r];
    endfunction

    function automatic logic exp_busy(int k, logic [2:0] sel);
        int r = int'(sel) % cd[k];
        if (cz[k] == 1 && r == 0) return 1'b0;
        if (cb[k] == 1 && we && int'(wsel) % cd[k] == r) return 1'b0;
        return mbusy[k][r];
    endfunction

    function automatic logic [7:0] exp_vec(int k);
        logic [7:0] v = '0;
        for (int i = 0; i < cd[k]; i++) v[i] = mbusy[k][i];
        return v;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("i%0d out_a", k), o_a[k], exp_out(k, rsel_a));
            chk($sformatf("i%0d out_b", k), o_b[k], exp_out(k, rsel_b));
            chk($sformatf("i%0d busy_a", k), 16'(ba[k]), 16'(exp_busy(k, rsel_a)));
            chk($sformatf("i%0d busy_b", k), 16'(bb[k]), 16'(exp_busy(k, rsel_b)));
            chk($sformatf("i%0d busy_vec", k), 16'(bv[k]), 16'(exp_vec(k)));
            chk($sformatf("i%0d res_err", k), 16'(re[k]), 16'(merr[k]));
        end
    end

    task automatic idle();
        we = 0; res_en = 0; clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0; idle(); wsel = 0; wdata = 0; rsel_a = 0; rsel_b = 0; res_sel = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        #1 chk("reset out_a", o_a[0], 16'h0);
        chk("reset busy_vec", 16'(bv[0]), 16'h0);

        // async reset mid-cycle wipes a stored value immediately
        we = 1; wsel = 2; wdata = 16'h00A5;
        tick(); idle(); rsel_a = 2;
        #1 chk("stored A5", o_a[0], 16'h00A5);
        rst_n = 0;
        #1 chk("async rst out_a", o_a[0], 16'h0);
        chk("async rst busy_vec", 16'(bv[0]), 16'h0);
        tick(); rst_n = 1; tick();
        #1 chk("post rst out_a", o_a[0], 16'h0);

        // bypass vs stored read
        we = 1; wsel = 1; wdata = 16'h003C; rsel_a = 1;
        #1 chk("bypass on", o_a[0], 16'h003C);
        chk("bypass off", o_a[1], 16'h0);
        tick(); idle();
        #1 chk("no-bypass next", o_a[1], 16'h003C);

        // scoreboard reserve then retire
        res_en = 1; res_sel = 3;
        tick(); idle(); rsel_b = 3;
        #1 chk("resv busy_vec", 16'(bv[0]), 16'h0008);
        chk("resv busy_b", 16'(bb[0]), 16'h1);
        we = 1; wsel = 3; wdata = 16'h007F;
        #1 chk("fwd busy_b", 16'(bb[0]), 16'h0);
        chk("nofwd busy_b", 16'(bb[1]), 16'h1);
        tick(); idle();
        #1 chk("retired busy_vec", 16'(bv[0]), 16'h0);

        // collision: write and reserve same register
        res_en = 1; res_sel = 2; we = 1; wsel = 2; wdata = 16'h0011;
        tick(); idle(); rsel_a = 2;
        #1 chk("coll data", o_a[0], 16'h0011);
        chk("coll busy", 16'(bv[0][2]), 16'h1);
        chk("coll err", 16'(re[0]), 16'h0);
        res_en = 1; res_sel = 2;
        tick(); idle();
        #1 chk("rereserve err", 16'(re[0]), 16'h1);
        tick();
        #1 chk("err one cycle", 16'(re[0]), 16'h0);

        // zero register
        we = 1; wsel = 0; wdata = 16'h00FF; rsel_a = 0;
        #1 chk("zreg same cycle", o_a[2], 16'h0);
        chk("nozreg bypass", o_a[0], 16'h00FF);
        tick(); idle();
        #1 chk("zreg after", o_a[2], 16'h0);
        res_en = 1; res_sel = 0;
        tick(); idle();
        #1 chk("zreg busy0", 16'(bv[2][0]), 16'h0);
        chk("zreg no err", 16'(re[2]), 16'h0);
        res_en = 1; res_sel = 0;
        tick(); idle();
        #1 chk("r0 double resv err", 16'(re[0]), 16'h1);
        chk("zreg double no err", 16'(re[2]), 16'h0);

        // wide/deep configuration and clear
        we = 1; wsel = 7; wdata = 16'hBEEF;
        tick();
        wsel = 0; wdata = 16'h1234;
        tick(); idle(); rsel_a = 7; rsel_b = 0;
        #1 chk("wide r7", o_a[3], 16'hBEEF);
        chk("wide r0", o_b[3], 16'h1234);
        clr = 1;
        tick(); clr = 0;
        #1 chk("clr r7", o_a[3], 16'h0);
        chk("clr r0", o_b[3], 16'h0);

        // mixed traffic against the model
        for (int c = 0; c < 80; c++) begin
            we      = 1'($urandom_range(0, 1));
            wsel    = 3'($urandom);
            wdata   = 16'($urandom);
            res_en  = 1'($urandom_range(0, 1));
            res_sel = 3'($urandom);
            rsel_a  = 3'($urandom);
            rsel_b  = 3'($urandom);
            clr     = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
